// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, address width,
// default counter width and the redirect-target selection helper.
package fetch_pkg;

   localparam int ADDR_W    = 16;
   localparam int CNT_W_DEF = 16;

   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_PAUSE  = 2'd2,
      ST_HALTED = 2'd3
   } state_e;

   // A redirect presented this cycle always beats one remembered from a stall.
   function automatic addr_t select_target(
      input logic  live_vld,
      input addr_t live_pc,
      input addr_t pend_pc
   );
      addr_t target;
      if (live_vld) begin
         target = live_pc;
      end else begin
         target = pend_pc;
      end
      return target;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts while inc is high and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: advance only when requested and not yet saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: decides each cycle whether the PC holds, increments or
// loads a redirect target, tolerating a variable-latency instruction memory,
// redirects arriving during stalls or pauses, HLT and a debug run-enable.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int BOOT_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_en,
   input  logic              imem_rdy,
   input  logic              hlt_instr,
   input  logic              redirect_vld,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] alt_pc,
   output logic              alt_pc_ctrl,
   output logic              hlt,
   output logic              halted,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instr_cnt
);

   // Last boot-counter value before the first fetch (BOOT_WAIT is 1..15).
   localparam logic [3:0] BOOT_LAST = 4'(BOOT_WAIT - 1);

   state_e      state_q;
   state_e      state_d;
   logic [3:0]  boot_cnt_q;
   logic [3:0]  boot_cnt_d;
   logic        pend_vld_q;
   logic        pend_vld_d;
   addr_t       pend_pc_q;
   addr_t       pend_pc_d;
   logic        halted_q;
   logic        halted_d;

   logic        retire_s;
   logic        cycle_inc_s;

   // An instruction retires whenever memory answers an outstanding fetch.
   assign retire_s    = (state_q == ST_FETCH) && imem_rdy;
   assign cycle_inc_s = (state_q != ST_HALTED);

   // State register, boot counter, pending redirect and halted flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         boot_cnt_q <= 4'd0;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= {ADDR_W{1'b0}};
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         boot_cnt_q <= boot_cnt_d;
         pend_vld_q <= pend_vld_d;
         pend_pc_q  <= pend_pc_d;
         halted_q   <= halted_d;
      end
   end

   // Next-state logic; an outstanding fetch always completes before pausing.
   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      case (state_q)
         ST_BOOT: begin
            if (boot_cnt_q == BOOT_LAST) begin
               boot_cnt_d = 4'd0;
               if (run_en) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_PAUSE;
               end
            end else begin
               boot_cnt_d = boot_cnt_q + 4'd1;
               state_d    = ST_BOOT;
            end
         end
         ST_FETCH: begin
            if (!imem_rdy) begin
               state_d = ST_FETCH;
            end else if (hlt_instr) begin
               state_d = ST_HALTED;
            end else if (!run_en) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_PAUSE: begin
            if (run_en) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d    = ST_BOOT;
            boot_cnt_d = 4'd0;
         end
      endcase
   end

   // The halted flag is registered and mirrors entry into HALTED.
   always_comb begin
      if (state_d == ST_HALTED) begin
         halted_d = 1'b1;
      end else begin
         halted_d = 1'b0;
      end
   end

   // Pending redirect: captured while the PC cannot move, consumed on retire.
   always_comb begin
      pend_vld_d = pend_vld_q;
      pend_pc_d  = pend_pc_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_rdy) begin
               // Consumed by a normal retire, discarded by HLT.
               pend_vld_d = 1'b0;
               pend_pc_d  = {ADDR_W{1'b0}};
            end else if (redirect_vld) begin
               pend_vld_d = 1'b1;
               pend_pc_d  = redirect_pc;
            end else begin
               pend_vld_d = pend_vld_q;
               pend_pc_d  = pend_pc_q;
            end
         end
         ST_PAUSE: begin
            if (redirect_vld) begin
               pend_vld_d = 1'b1;
               pend_pc_d  = redirect_pc;
            end else begin
               pend_vld_d = pend_vld_q;
               pend_pc_d  = pend_pc_q;
            end
         end
         ST_BOOT, ST_HALTED: begin
            pend_vld_d = pend_vld_q;
            pend_pc_d  = pend_pc_q;
         end
         default: begin
            pend_vld_d = 1'b0;
            pend_pc_d  = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Combinational PC controls consumed by the PC register the same cycle.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      hlt         = 1'b1;
      alt_pc_ctrl = 1'b0;
      alt_pc      = {ADDR_W{1'b0}};
      case (state_q)
         ST_FETCH: begin
            imem_req    = 1'b1;
            instr_valid = retire_s;
            hlt         = ~retire_s | hlt_instr;
            if (retire_s && !hlt_instr && (redirect_vld || pend_vld_q)) begin
               alt_pc_ctrl = 1'b1;
               alt_pc      = select_target(redirect_vld, redirect_pc, pend_pc_q);
            end else begin
               alt_pc_ctrl = 1'b0;
               alt_pc      = {ADDR_W{1'b0}};
            end
         end
         ST_BOOT, ST_PAUSE, ST_HALTED: begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            hlt         = 1'b1;
         end
         default: begin
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            hlt         = 1'b1;
         end
      endcase
   end

   assign halted = halted_q;

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cycle_inc_s),
      .count (cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire_s),
      .count (instr_cnt)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run checked
// against a behavioural model; a second instance with 4-bit counters covers
// saturation.
module tb_fetch_sequencer;

   localparam int BW = 2;

   logic        clk = 1'b0;
   logic        rst, run_en, imem_rdy, hlt_instr, redirect_vld;
   logic [15:0] redirect_pc;

   logic        imem_req, instr_valid, alt_pc_ctrl, hlt, halted;
   logic [15:0] alt_pc, cycle_cnt, instr_cnt;

   logic        imem_req4, instr_valid4, alt_pc_ctrl4, hlt4, halted4;
   logic [15:0] alt_pc4;
   logic [3:0]  cycle_cnt4, instr_cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.CNT_W(16), .BOOT_WAIT(BW)) dut (
      .clk(clk), .rst(rst), .run_en(run_en), .imem_rdy(imem_rdy),
      .hlt_instr(hlt_instr), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .instr_valid(instr_valid), .alt_pc(alt_pc),
      .alt_pc_ctrl(alt_pc_ctrl), .hlt(hlt), .halted(halted),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   fetch_sequencer #(.CNT_W(4), .BOOT_WAIT(BW)) dut4 (
      .clk(clk), .rst(rst), .run_en(run_en), .imem_rdy(imem_rdy),
      .hlt_instr(hlt_instr), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
      .imem_req(imem_req4), .instr_valid(instr_valid4), .alt_pc(alt_pc4),
      .alt_pc_ctrl(alt_pc_ctrl4), .hlt(hlt4), .halted(halted4),
      .cycle_cnt(cycle_cnt4), .instr_cnt(instr_cnt4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      run_en       = 1'b1;
      imem_rdy     = 1'b0;
      hlt_instr    = 1'b0;
      redirect_vld = 1'b0;
      redirect_pc  = 16'h0000;
   endtask

   // Reset and wait out BOOT; returns in the first FETCH cycle.
   task automatic boot(input logic rdy);
      idle_inputs();
      imem_rdy = rdy;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      repeat (BW) tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      imem_rdy = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      settle();
      checks++;
      if ({hlt, imem_req, instr_valid, alt_pc_ctrl, halted} !== 5'b10000) begin
         errors++; $display("FAIL reset_ctrl got %b want 10000", {hlt, imem_req, instr_valid, alt_pc_ctrl, halted});
      end
      checks++;
      if ({alt_pc, cycle_cnt, instr_cnt} !== 48'h0) begin
         errors++; $display("FAIL reset_values alt=%h cyc=%0d ins=%0d want 0", alt_pc, cycle_cnt, instr_cnt);
      end
      tick(); settle();
      checks++;
      if ({hlt, imem_req, instr_valid} !== 3'b100) begin
         errors++; $display("FAIL boot_cycle2 got %b want 100", {hlt, imem_req, instr_valid});
      end
      tick(); settle();
      checks++;
      if ({hlt, imem_req, instr_valid} !== 3'b011) begin
         errors++; $display("FAIL first_fetch got %b want 011", {hlt, imem_req, instr_valid});
      end
      tick();
      checks++;
      if (cycle_cnt !== 16'd3 || instr_cnt !== 16'd1) begin
         errors++; $display("FAIL boot_counts cyc=%0d ins=%0d want 3/1", cycle_cnt, instr_cnt);
      end
   endtask

   task automatic test_stall_redirect();
      boot(1'b0);
      for (int i = 0; i < 4; i++) begin
         redirect_vld = (i < 2);
         redirect_pc  = (i == 0) ? 16'h0040 : 16'h0080;
         settle();
         checks++;
         if (hlt !== 1'b1 || instr_valid !== 1'b0 || alt_pc_ctrl !== 1'b0) begin
            errors++; $display("FAIL stall_hold[%0d] hlt=%b iv=%b ctrl=%b want 1/0/0", i, hlt, instr_valid, alt_pc_ctrl);
         end
         tick();
      end
      redirect_vld = 1'b0;
      imem_rdy     = 1'b1;
      settle();
      checks++;
      if (alt_pc_ctrl !== 1'b1 || alt_pc !== 16'h0080 || instr_valid !== 1'b1 || hlt !== 1'b0) begin
         errors++; $display("FAIL stall_retire ctrl=%b alt=%h iv=%b hlt=%b want 1/0080/1/0", alt_pc_ctrl, alt_pc, instr_valid, hlt);
      end
      tick();
      checks++;
      if (instr_cnt !== 16'd1) begin
         errors++; $display("FAIL stall_icnt got %0d want 1", instr_cnt);
      end
   endtask

   task automatic test_live_vs_pending();
      boot(1'b0);
      redirect_vld = 1'b1;
      redirect_pc  = 16'h0010;
      settle(); tick();
      redirect_pc = 16'h0020;
      imem_rdy    = 1'b1;
      settle();
      checks++;
      if (alt_pc_ctrl !== 1'b1 || alt_pc !== 16'h0020) begin
         errors++; $display("FAIL live_wins ctrl=%b alt=%h want 1/0020", alt_pc_ctrl, alt_pc);
      end
      tick();
      redirect_vld = 1'b0;
      settle();
      checks++;
      if (alt_pc_ctrl !== 1'b0 || instr_valid !== 1'b1) begin
         errors++; $display("FAIL pend_cleared ctrl=%b iv=%b want 0/1", alt_pc_ctrl, instr_valid);
      end
      tick();
   endtask

   task automatic test_hlt();
      boot(1'b1);
      settle();
      checks++;
      if (halted !== 1'b0) begin
         errors++; $display("FAIL hlt_pre got %b want 0", halted);
      end
      tick();
      hlt_instr    = 1'b1;
      redirect_vld = 1'b1;
      redirect_pc  = 16'h0055;
      settle();
      checks++;
      if ({alt_pc_ctrl, hlt, instr_valid, halted} !== 4'b0110) begin
         errors++; $display("FAIL hlt_retire got %b want 0110", {alt_pc_ctrl, hlt, instr_valid, halted});
      end
      tick();
      hlt_instr    = 1'b0;
      redirect_vld = 1'b0;
      settle();
      checks++;
      if ({halted, hlt, imem_req} !== 3'b110) begin
         errors++; $display("FAIL hlt_state got %b want 110", {halted, hlt, imem_req});
      end
      for (int i = 0; i < 8; i++) begin
         imem_rdy     = i[0];
         hlt_instr    = i[0];
         redirect_vld = i[1];
         run_en       = ~i[2];
         settle();
         checks++;
         if ({halted, hlt, imem_req, instr_valid, alt_pc_ctrl} !== 5'b11000) begin
            errors++; $display("FAIL hlt_ignore[%0d] got %b want 11000", i, {halted, hlt, imem_req, instr_valid, alt_pc_ctrl});
         end
         tick();
      end
      checks++;
      if (cycle_cnt !== 16'(BW + 2) || instr_cnt !== 16'd2) begin
         errors++; $display("FAIL hlt_frozen cyc=%0d ins=%0d want %0d/2", cycle_cnt, instr_cnt, BW + 2);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      checks++;
      if ({halted, hlt, imem_req} !== 3'b010 || cycle_cnt !== 16'd0 || instr_cnt !== 16'd0) begin
         errors++; $display("FAIL hlt_rst got %b cyc=%0d ins=%0d want 010/0/0", {halted, hlt, imem_req}, cycle_cnt, instr_cnt);
      end
      idle_inputs();
   endtask

   task automatic test_pause();
      boot(1'b0);
      settle(); tick();
      run_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         checks++;
         if (imem_req !== 1'b1 || hlt !== 1'b1) begin
            errors++; $display("FAIL pause_stall[%0d] req=%b hlt=%b want 1/1", i, imem_req, hlt);
         end
         tick();
      end
      imem_rdy = 1'b1;
      settle();
      checks++;
      if ({instr_valid, alt_pc_ctrl, hlt} !== 3'b100) begin
         errors++; $display("FAIL pause_retire got %b want 100", {instr_valid, alt_pc_ctrl, hlt});
      end
      tick();
      redirect_vld = 1'b1;
      redirect_pc  = 16'h0100;
      settle();
      checks++;
      if ({imem_req, hlt, instr_valid} !== 3'b010) begin
         errors++; $display("FAIL pause_state got %b want 010", {imem_req, hlt, instr_valid});
      end
      tick();
      redirect_vld = 1'b0;
      run_en       = 1'b1;
      settle();
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL pause_exit got %b want 0", imem_req);
      end
      tick();
      settle();
      checks++;
      if (alt_pc_ctrl !== 1'b1 || alt_pc !== 16'h0100 || instr_valid !== 1'b1) begin
         errors++; $display("FAIL pause_redirect ctrl=%b alt=%h iv=%b want 1/0100/1", alt_pc_ctrl, alt_pc, instr_valid);
      end
      tick();
      checks++;
      if (instr_cnt !== 16'd2) begin
         errors++; $display("FAIL pause_icnt got %0d want 2", instr_cnt);
      end
   endtask

   task automatic test_saturation();
      idle_inputs();
      imem_rdy = 1'b1;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      repeat (30) tick();
      checks++;
      if (instr_cnt4 !== 4'hF || cycle_cnt4 !== 4'hF) begin
         errors++; $display("FAIL sat4 ins=%h cyc=%h want F/F", instr_cnt4, cycle_cnt4);
      end
      checks++;
      if (instr_cnt !== 16'd28 || cycle_cnt !== 16'd30) begin
         errors++; $display("FAIL sat16_ref ins=%0d cyc=%0d want 28/30", instr_cnt, cycle_cnt);
      end
      repeat (5) tick();
      checks++;
      if (instr_cnt4 !== 4'hF || cycle_cnt4 !== 4'hF || instr_cnt !== 16'd33) begin
         errors++; $display("FAIL sat_hold ins4=%h cyc4=%h ins=%0d want F/F/33", instr_cnt4, cycle_cnt4, instr_cnt);
      end
   endtask

   // Randomized run against a model built from the behavioural rules.
   task automatic test_random();
      bit          known = 1'b0;
      int          boot_left = 0;
      bit          paused = 1'b0;
      bit          stopped = 1'b0;
      bit          pend = 1'b0;
      logic [15:0] pend_pc = 16'h0;
      int          cyc = 0;
      int          ins = 0;
      logic [4:0]  exp_v;
      logic [15:0] exp_alt;
      bit          fetching;
      for (int n = 0; n < 3000; n++) begin
         rst          = (n < 2) || ($urandom_range(0, 63) == 0);
         run_en       = ($urandom_range(0, 7) != 0);
         imem_rdy     = ($urandom_range(0, 2) == 0);
         hlt_instr    = ($urandom_range(0, 24) == 0);
         redirect_vld = ($urandom_range(0, 3) == 0);
         redirect_pc  = 16'($urandom);
         settle();
         fetching = known && (boot_left == 0) && !paused && !stopped;
         if (known && !rst) begin
            exp_alt = 16'h0;
            if (fetching) begin
               exp_v = {1'b1, imem_rdy, ~imem_rdy | hlt_instr, 1'b0,
                        imem_rdy & ~hlt_instr & (redirect_vld | pend)};
               exp_alt = redirect_vld ? redirect_pc : pend_pc;
            end else begin
               exp_v = {1'b0, 1'b0, 1'b1, stopped, 1'b0};
            end
            checks++;
            if ({imem_req, instr_valid, hlt, halted, alt_pc_ctrl} !== exp_v) begin
               errors++; $display("FAIL rand_ctrl n=%0d got %b want %b", n, {imem_req, instr_valid, hlt, halted, alt_pc_ctrl}, exp_v);
            end
            checks++;
            if ({imem_req4, instr_valid4, hlt4, halted4, alt_pc_ctrl4} !== exp_v) begin
               errors++; $display("FAIL rand_ctrl4 n=%0d got %b want %b", n, {imem_req4, instr_valid4, hlt4, halted4, alt_pc_ctrl4}, exp_v);
            end
            if (exp_v[0]) begin
               checks++;
               if (alt_pc !== exp_alt || alt_pc4 !== exp_alt) begin
                  errors++; $display("FAIL rand_alt n=%0d got %h/%h want %h", n, alt_pc, alt_pc4, exp_alt);
               end
            end
            checks++;
            if (cycle_cnt !== 16'(cyc) || instr_cnt !== 16'(ins)) begin
               errors++; $display("FAIL rand_cnt n=%0d got %0d/%0d want %0d/%0d", n, cycle_cnt, instr_cnt, cyc, ins);
            end
            checks++;
            if (cycle_cnt4 !== 4'((cyc > 15) ? 15 : cyc) || instr_cnt4 !== 4'((ins > 15) ? 15 : ins)) begin
               errors++; $display("FAIL rand_cnt4 n=%0d got %0d/%0d want %0d/%0d", n, cycle_cnt4, instr_cnt4,
                                  (cyc > 15) ? 15 : cyc, (ins > 15) ? 15 : ins);
            end
         end
         tick();
         if (rst) begin
            known = 1'b1; boot_left = BW; paused = 1'b0; stopped = 1'b0;
            pend = 1'b0; pend_pc = 16'h0; cyc = 0; ins = 0;
         end else if (known) begin
            if (!stopped) cyc++;
            if (boot_left > 0) begin
               boot_left--;
               if (boot_left == 0 && !run_en) paused = 1'b1;
            end else if (paused) begin
               if (redirect_vld) begin pend = 1'b1; pend_pc = redirect_pc; end
               if (run_en) paused = 1'b0;
            end else if (!stopped) begin
               if (imem_rdy) begin
                  ins++;
                  pend = 1'b0;
                  if (hlt_instr) stopped = 1'b1;
                  else if (!run_en) paused = 1'b1;
               end else if (redirect_vld) begin
                  pend = 1'b1; pend_pc = redirect_pc;
               end
            end
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_stall_redirect();
      test_live_vs_pending();
      test_hlt();
      test_pause();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
